// File: rtl/instr_fetch_queue.sv
// -----------------------------------------------------------------------------
// instr_fetch_queue
//
// Instruction fetch stage between the program counter and decode. The PC drives
// a combinational instruction ROM directly. Each returned word is captured,
// tagged with the PC it came from, into a small circular FIFO. Decode sees the
// FIFO head through a valid/ready handshake. A taken branch or jump (redirect)
// flushes the FIFO and reloads the PC. Halt freezes fetching while the FIFO
// keeps draining.
//
// Ports
//   clk             rising-edge clock
//   reset           asynchronous, active-high reset
//   rom_addr        ROM address (the PC register itself)
//   rom_data        ROM read data, valid in the same cycle as rom_addr
//   redirect_valid  taken branch/jump: flush the FIFO, load redirect_pc
//   redirect_pc     new PC used when redirect_valid is high
//   halt            suppresses new fetches and freezes the PC
//   instr           instruction at the FIFO head
//   instr_pc        PC of the instruction at the FIFO head
//   instr_valid     FIFO non-empty
//   instr_ready     decode accepts the head this cycle
// -----------------------------------------------------------------------------
module instr_fetch_queue #(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] pc;
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic pop;
  logic room;
  logic push;

  // Handshake decisions come purely from registered state plus the inputs of
  // this cycle; instr_ready only influences what happens at the next edge.
  always_comb begin
    pop  = instr_valid & instr_ready;
    // A pop frees a slot in the same cycle, so a full FIFO can still accept.
    room = (count < FULL_CNT) | pop;
    push = ~redirect_valid & ~halt & room;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc    <= RESET_PC;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        data_mem[i] <= '0;
      end
    end else if (redirect_valid) begin
      // Flush: any pop in this cycle is discarded along with the queue.
      pc    <= redirect_pc;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        pc_mem[wptr]   <= pc;
        data_mem[wptr] <= rom_data;
        wptr           <= wptr + PTR_W'(1);
        // Word-addressed PC, wraps naturally at the top of the address space.
        pc             <= pc + ADDR_W'(1);
      end
      if (pop) begin
        rptr <= rptr + PTR_W'(1);
      end
      // Simultaneous push and pop leave the occupancy unchanged, even when full.
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign rom_addr    = pc;
  assign instr       = data_mem[rptr];
  assign instr_pc    = pc_mem[rptr];
  assign instr_valid = (count != '0);

endmodule

// File: tb/tb_instr_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_queue
//
// Directed bench for instr_fetch_queue. The ROM is modelled as
// ROM[n] = n + 16'h0100 (16-bit wrap). Expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_instr_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] rom_addr;
  logic [15:0] rom_data;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        halt;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign rom_data = rom_addr + 16'h0100;

  instr_fetch_queue #(
    .ADDR_W  (16),
    .DATA_W  (16),
    .RESET_PC(16'h0000),
    .DEPTH   (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .halt          (halt),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    halt           = 1'b0;
    instr_ready    = 1'b0;

    // Reset state, before any clock edge.
    #2;
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_addr",  32'(rom_addr),    32'h0000);
    chk("rst_instr", 32'(instr),       32'h0000);
    chk("rst_pc",    32'(instr_pc),    32'h0000);

    // 1: streaming with ready=1.
    do_reset();
    instr_ready = 1'b1;
    chk("t1_pre_valid", 32'(instr_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("t1_valid%0d", i), 32'(instr_valid), 32'd1);
      chk($sformatf("t1_pc%0d", i),    32'(instr_pc),    32'(i));
      chk($sformatf("t1_instr%0d", i), 32'(instr),       32'(16'h0100 + i));
    end

    // 2: ready=0 from reset, FIFO fills, then drains in order.
    instr_ready = 1'b0;
    do_reset();
    step();
    step();
    chk("t2_full_valid", 32'(instr_valid), 32'd1);
    chk("t2_full_pc",    32'(instr_pc),    32'h0000);
    chk("t2_full_addr",  32'(rom_addr),    32'h0002);
    step();
    chk("t2_hold_pc",    32'(instr_pc),    32'h0000);
    chk("t2_hold_instr", 32'(instr),       32'h0100);
    chk("t2_hold_addr",  32'(rom_addr),    32'h0002);
    instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_valid%0d", i), 32'(instr_valid), 32'd1);
      chk($sformatf("t2_pc%0d", i),    32'(instr_pc),    32'(i));
      step();
    end

    // 3: redirect while full (head pc 4, two entries queued).
    chk("t3_pre_pc", 32'(instr_pc), 32'h0004);
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0040;
    step();
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;
    chk("t3_flush_valid", 32'(instr_valid), 32'd0);
    chk("t3_flush_addr",  32'(rom_addr),    32'h0040);
    step();
    chk("t3_tgt_valid", 32'(instr_valid), 32'd1);
    chk("t3_tgt_pc",    32'(instr_pc),    32'h0040);
    chk("t3_tgt_instr", 32'(instr),       32'h0140);

    // 4: halt with two entries queued, FIFO drains, PC frozen.
    step();
    chk("t4_addr_full", 32'(rom_addr), 32'h0042);
    halt        = 1'b1;
    instr_ready = 1'b1;
    chk("t4_head0", 32'(instr_pc), 32'h0040);
    step();
    chk("t4_head1",  32'(instr_pc),    32'h0041);
    chk("t4_valid1", 32'(instr_valid), 32'd1);
    step();
    chk("t4_empty",  32'(instr_valid), 32'd0);
    chk("t4_frozen", 32'(rom_addr),    32'h0042);
    step();
    chk("t4_empty2",  32'(instr_valid), 32'd0);
    chk("t4_frozen2", 32'(rom_addr),    32'h0042);
    halt = 1'b0;
    step();
    chk("t4_res_valid", 32'(instr_valid), 32'd1);
    chk("t4_res_pc",    32'(instr_pc),    32'h0042);
    chk("t4_res_instr", 32'(instr),       32'h0142);
    step();
    chk("t4_res_pc2", 32'(instr_pc), 32'h0043);

    // 5: redirect to the top of the address space, PC wraps.
    redirect_valid = 1'b1;
    redirect_pc    = 16'hFFFF;
    step();
    redirect_valid = 1'b0;
    chk("t5_flush_valid", 32'(instr_valid), 32'd0);
    chk("t5_flush_addr",  32'(rom_addr),    32'hFFFF);
    step();
    chk("t5_pc_top",    32'(instr_pc), 32'hFFFF);
    chk("t5_instr_top", 32'(instr),    32'h00FF);
    step();
    chk("t5_pc_wrap",    32'(instr_pc), 32'h0000);
    chk("t5_instr_wrap", 32'(instr),    32'h0100);

    // 6: asynchronous reset between edges.
    #3;
    reset = 1'b1;
    #1;
    chk("t6_async_valid", 32'(instr_valid), 32'd0);
    chk("t6_async_addr",  32'(rom_addr),    32'h0000);
    chk("t6_async_pc",    32'(instr_pc),    32'h0000);
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("t6_pc%0d", i),    32'(instr_pc), 32'(i));
      chk($sformatf("t6_instr%0d", i), 32'(instr),    32'(16'h0100 + i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
